// File: rtl/axi_rd_arbiter_if.sv
// Signal bundle between the I/D-cache refill engines, the read arbiter and the AXI AR/R channels.
// The arbiter uses the master view; the surrounding caches and AXI slave use the slave view.
interface axi_rd_arbiter_if;
    logic [31:0] i_araddr;
    logic [7:0]  i_arlen;
    logic        i_arvalid;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        i_rlast;
    logic        i_rready;

    logic [31:0] d_araddr;
    logic [7:0]  d_arlen;
    logic        d_arvalid;
    logic        d_arready;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_rlast;
    logic        d_rready;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        proto_err;

    modport master (
        input  i_araddr, i_arlen, i_arvalid, i_rready,
        output i_arready, i_rdata, i_rvalid, i_rlast,
        input  d_araddr, d_arlen, d_arvalid, d_rready,
        output d_arready, d_rdata, d_rvalid, d_rlast,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready, proto_err,
        input  arready, rid, rdata, rlast, rvalid
    );

    modport slave (
        output i_araddr, i_arlen, i_arvalid, i_rready,
        input  i_arready, i_rdata, i_rvalid, i_rlast,
        output d_araddr, d_arlen, d_arvalid, d_rready,
        input  d_arready, d_rdata, d_rvalid, d_rlast,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready, proto_err,
        output arready, rid, rdata, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read channel between I-cache and D-cache; one burst in flight, AR issued one
// cycle after the request is seen in IDLE, R beats routed to the granted side only.
module axi_rd_arbiter #(
    parameter bit         RR_EN = 1'b1,
    parameter logic [3:0] ID_I  = 4'd0,
    parameter logic [3:0] ID_D  = 4'd1
) (
    input  logic           clk,
    input  logic           resetn,
    axi_rd_arbiter_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        gnt_d_q, gnt_d_d;
    logic        last_d_q, last_d_d;
    logic [3:0]  arid_q, arid_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [7:0]  beat_q, beat_d;
    logic        err_q, err_d;

    logic in_addr, in_data, g_rready, r_hs, pick_d;

    assign in_addr  = (state_q == S_ADDR);
    assign in_data  = (state_q == S_DATA);
    assign g_rready = gnt_d_q ? bus.d_rready : bus.i_rready;
    assign r_hs     = bus.rvalid & bus.rready;

    // On a tie the D-cache wins unless round-robin is on and it was served last.
    assign pick_d = bus.d_arvalid & (~bus.i_arvalid | ~RR_EN | ~last_d_q);

    always_comb begin
        state_d  = state_q;
        gnt_d_d  = gnt_d_q;
        last_d_d = last_d_q;
        arid_d   = arid_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        beat_d   = beat_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_arvalid | bus.d_arvalid) begin
                    state_d  = S_ADDR;
                    gnt_d_d  = pick_d;
                    last_d_d = pick_d;
                    arid_d   = pick_d ? ID_D : ID_I;
                    araddr_d = pick_d ? bus.d_araddr : bus.i_araddr;
                    arlen_d  = pick_d ? bus.d_arlen : bus.i_arlen;
                end
            end
            S_ADDR: begin
                if (bus.arready) begin
                    state_d = S_DATA;
                    beat_d  = 8'd0;
                end
            end
            S_DATA: begin
                if (r_hs) begin
                    beat_d = beat_q + 8'd1;
                    if (bus.rid != arid_q) err_d = 1'b1;
                    if (bus.rlast) begin
                        // A short or long burst is flagged but still terminates on rlast.
                        if (beat_q != arlen_q) err_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            gnt_d_q  <= 1'b0;
            last_d_q <= 1'b0;
            arid_q   <= ID_I;
            araddr_q <= 32'd0;
            arlen_q  <= 8'd0;
            beat_q   <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_d_q  <= gnt_d_d;
            last_d_q <= last_d_d;
            arid_q   <= arid_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
        end
    end

    assign bus.arid      = arid_q;
    assign bus.araddr    = araddr_q;
    assign bus.arlen     = arlen_q;
    assign bus.arsize    = 3'b010;
    assign bus.arburst   = 2'b01;
    assign bus.arvalid   = in_addr;
    assign bus.rready    = g_rready & in_data;
    assign bus.proto_err = err_q;

    assign bus.i_arready = bus.arready & in_addr & ~gnt_d_q;
    assign bus.d_arready = bus.arready & in_addr & gnt_d_q;
    assign bus.i_rvalid  = bus.rvalid & in_data & ~gnt_d_q;
    assign bus.d_rvalid  = bus.rvalid & in_data & gnt_d_q;
    assign bus.i_rlast   = bus.rlast & in_data & ~gnt_d_q;
    assign bus.d_rlast   = bus.rlast & in_data & gnt_d_q;
    assign bus.i_rdata   = bus.rdata;
    assign bus.d_rdata   = bus.rdata;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: round-robin and fixed-priority instances share one stimulus set.
`timescale 1ns/1ps
module tb_axi_rd_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        sel_fp;
    logic [31:0] i_araddr, d_araddr, rdata;
    logic [7:0]  i_arlen, d_arlen;
    logic        i_arvalid, d_arvalid, i_rready, d_rready, arready, rlast, rvalid;
    logic [3:0]  rid;

    axi_rd_arbiter_if bus_rr();
    axi_rd_arbiter_if bus_fp();

    axi_rd_arbiter #(.RR_EN(1'b1), .ID_I(4'd0), .ID_D(4'd1)) dut_rr (.clk(clk), .resetn(resetn), .bus(bus_rr));
    axi_rd_arbiter #(.RR_EN(1'b0), .ID_I(4'd0), .ID_D(4'd1)) dut_fp (.clk(clk), .resetn(resetn), .bus(bus_fp));

    always_comb begin
        bus_rr.i_araddr = i_araddr; bus_rr.i_arlen = i_arlen; bus_rr.i_arvalid = i_arvalid; bus_rr.i_rready = i_rready;
        bus_rr.d_araddr = d_araddr; bus_rr.d_arlen = d_arlen; bus_rr.d_arvalid = d_arvalid; bus_rr.d_rready = d_rready;
        bus_rr.arready = arready; bus_rr.rid = rid; bus_rr.rdata = rdata; bus_rr.rlast = rlast; bus_rr.rvalid = rvalid;
        bus_fp.i_araddr = i_araddr; bus_fp.i_arlen = i_arlen; bus_fp.i_arvalid = i_arvalid; bus_fp.i_rready = i_rready;
        bus_fp.d_araddr = d_araddr; bus_fp.d_arlen = d_arlen; bus_fp.d_arvalid = d_arvalid; bus_fp.d_rready = d_rready;
        bus_fp.arready = arready; bus_fp.rid = rid; bus_fp.rdata = rdata; bus_fp.rlast = rlast; bus_fp.rvalid = rvalid;
    end

    wire [3:0]  o_arid      = sel_fp ? bus_fp.arid      : bus_rr.arid;
    wire [31:0] o_araddr    = sel_fp ? bus_fp.araddr    : bus_rr.araddr;
    wire [7:0]  o_arlen     = sel_fp ? bus_fp.arlen     : bus_rr.arlen;
    wire [2:0]  o_arsize    = sel_fp ? bus_fp.arsize    : bus_rr.arsize;
    wire [1:0]  o_arburst   = sel_fp ? bus_fp.arburst   : bus_rr.arburst;
    wire        o_arvalid   = sel_fp ? bus_fp.arvalid   : bus_rr.arvalid;
    wire        o_rready    = sel_fp ? bus_fp.rready    : bus_rr.rready;
    wire        o_err       = sel_fp ? bus_fp.proto_err : bus_rr.proto_err;
    wire        o_i_arready = sel_fp ? bus_fp.i_arready : bus_rr.i_arready;
    wire        o_d_arready = sel_fp ? bus_fp.d_arready : bus_rr.d_arready;
    wire        o_i_rvalid  = sel_fp ? bus_fp.i_rvalid  : bus_rr.i_rvalid;
    wire        o_d_rvalid  = sel_fp ? bus_fp.d_rvalid  : bus_rr.d_rvalid;
    wire        o_i_rlast   = sel_fp ? bus_fp.i_rlast   : bus_rr.i_rlast;
    wire        o_d_rlast   = sel_fp ? bus_fp.d_rlast   : bus_rr.d_rlast;
    wire [31:0] o_i_rdata   = sel_fp ? bus_fp.i_rdata   : bus_rr.i_rdata;
    wire [31:0] o_d_rdata   = sel_fp ? bus_fp.d_rdata   : bus_rr.d_rdata;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    // Returns at a negedge with arvalid high, or with cyc > 50 on timeout.
    task automatic wait_ar(output int cyc);
        cyc = 0;
        while (cyc <= 50) begin
            @(negedge clk);
            if (o_arvalid === 1'b1) return;
            cyc++;
            tick();
        end
    endtask

    // Acts as the AXI slave for one burst and checks AR fields and R routing for the expected winner.
    task automatic serve(input bit sd, input logic [31:0] addr, input logic [7:0] len, input int ar_wait,
                         input int nbeats, input int bad_beat, input bit bp, output int gap);
        int hs, route_err, cyc, stall_err;
        bit got_last, own_rdy;
        logic [3:0] id;
        id = sd ? 4'd1 : 4'd0;
        wait_ar(gap);
        chk("arvalid_seen", 32'(gap <= 50), 32'd1);
        chk("arid", 32'(o_arid), 32'(id));
        chk("araddr", o_araddr, addr);
        chk("arlen", 32'(o_arlen), 32'(len));
        chk("arsize_burst", 32'({o_arsize, o_arburst}), 32'h09);
        stall_err = 0;
        for (int k = 0; k < ar_wait; k++) begin
            tick();
            @(negedge clk);
            if (o_arvalid !== 1'b1 || o_i_arready !== 1'b0 || o_d_arready !== 1'b0) stall_err++;
        end
        arready = 1'b1;
        #1;
        chk("ar_stall", 32'(stall_err), 32'd0);
        chk("g_arready", 32'({o_i_arready, o_d_arready}), sd ? 32'd1 : 32'd2);
        tick();
        arready = 1'b0;
        if (sd) d_arvalid = 1'b0; else i_arvalid = 1'b0;
        hs = 0; route_err = 0; cyc = 0; got_last = 1'b0;
        while (hs < nbeats && cyc < 200) begin
            rvalid = 1'b1;
            rdata  = 32'hA0 + 32'(hs);
            rlast  = (hs == nbeats - 1);
            rid    = (hs == bad_beat) ? 4'd2 : id;
            own_rdy = bp ? (cyc % 2 == 0) : 1'b1;
            if (sd) begin d_rready = own_rdy; i_rready = bp ? !own_rdy : 1'b1; end
            else    begin i_rready = own_rdy; d_rready = bp ? !own_rdy : 1'b1; end
            @(negedge clk);
            if (o_rready !== own_rdy) route_err++;
            if ((sd ? {o_d_rvalid, o_i_rvalid} : {o_i_rvalid, o_d_rvalid}) !== 2'b10) route_err++;
            if ((sd ? {o_d_rlast, o_i_rlast} : {o_i_rlast, o_d_rlast}) !== {rlast, 1'b0}) route_err++;
            if (o_i_rdata !== rdata || o_d_rdata !== rdata) route_err++;
            if (o_rready === 1'b1) begin
                hs++;
                if (rlast) got_last = 1'b1;
            end
            cyc++;
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0; i_rready = 1'b1; d_rready = 1'b1;
        chk("beats", 32'(hs), 32'(nbeats));
        chk("route", 32'(route_err), 32'd0);
        chk("rlast_seen", 32'(got_last), 32'd1);
    endtask

    typedef struct {
        bit          i_req;
        bit          d_req;
        bit          exp_d;
        logic [31:0] i_addr;
        logic [31:0] d_addr;
        logic [7:0]  len;
        int          ar_wait;
        bit          bp;
        int          exp_gap;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int gap, bad, ln;
        bit ni, nd, win_d, pend_i, pend_d, last_d;

        // Round-robin instance, starting from reset (last grant = I-cache).
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h1FC0_0100, 32'h8000_0000, 8'd7, 2, 1'b0, 0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h1FC0_0200, 32'h8000_0040, 8'd3, 0, 1'b0, 0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h1FC0_0200, 32'h8000_0080, 8'd2, 1, 1'b0, 2};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h1FC0_0300, 32'h8000_00C0, 8'd3, 0, 1'b1, 0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h1FC0_0400, 32'h8000_0100, 8'd0, 0, 1'b0, 0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h1FC0_0500, 32'h8000_0140, 8'd1, 3, 1'b1, 2};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h1FC0_0600, 32'h8000_0180, 8'd1, 0, 1'b0, 0};

        sel_fp = 1'b0;
        i_araddr = '0; d_araddr = '0; i_arlen = '0; d_arlen = '0;
        i_arvalid = 1'b0; d_arvalid = 1'b0; i_rready = 1'b1; d_rready = 1'b1;
        arready = 1'b1; rid = 4'd5; rdata = 32'hDEAD_BEEF; rlast = 1'b1; rvalid = 1'b1;
        resetn = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_ctl", 32'({o_arvalid, o_rready, o_err, o_i_arready, o_d_arready,
                            o_i_rvalid, o_d_rvalid, o_i_rlast, o_d_rlast}), 32'd0);
        chk("rst_araddr", o_araddr, 32'd0);
        chk("rst_arlen_id", 32'({o_arlen, o_arid}), 32'd0);

        // Stray R traffic in IDLE must be ignored.
        resetn = 1'b1;
        arready = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            if (o_rready !== 1'b0 || o_i_rvalid !== 1'b0 || o_d_rvalid !== 1'b0 || o_arvalid !== 1'b0) bad++;
        end
        chk("idle_r_ignored", 32'(bad), 32'd0);
        chk("idle_r_no_err", 32'(o_err), 32'd0);
        rvalid = 1'b0; rlast = 1'b0;
        tick();

        for (int r = 0; r < 7; r++) begin
            i_arvalid = tbl[r].i_req; d_arvalid = tbl[r].d_req;
            i_araddr = tbl[r].i_addr; d_araddr = tbl[r].d_addr;
            i_arlen = tbl[r].len; d_arlen = tbl[r].len;
            serve(tbl[r].exp_d, tbl[r].exp_d ? tbl[r].d_addr : tbl[r].i_addr, tbl[r].len,
                  tbl[r].ar_wait, int'(tbl[r].len) + 1, -1, tbl[r].bp, gap);
            if (tbl[r].exp_gap > 0) chk("rlast_to_arvalid", 32'(gap + 1), 32'(tbl[r].exp_gap));
        end
        @(negedge clk);
        chk("table_no_err", 32'(o_err), 32'd0);

        // Randomized traffic against a request-level model of the arbitration rules.
        i_arvalid = 1'b0; d_arvalid = 1'b0;
        do_reset();
        pend_i = 1'b0; pend_d = 1'b0; last_d = 1'b0;
        for (int r = 0; r < 25; r++) begin
            ni = 1'($urandom_range(0, 1));
            nd = 1'($urandom_range(0, 1));
            if (!ni && !nd && !pend_i && !pend_d) ni = 1'b1;
            pend_i = pend_i | ni;
            pend_d = pend_d | nd;
            win_d = (pend_i && pend_d) ? !last_d : pend_d;
            i_arvalid = pend_i; d_arvalid = pend_d;
            i_araddr = $urandom; d_araddr = $urandom;
            i_arlen = 8'($urandom_range(0, 7)); d_arlen = 8'($urandom_range(0, 7));
            ln = win_d ? int'(d_arlen) : int'(i_arlen);
            serve(win_d, win_d ? d_araddr : i_araddr, 8'(ln), $urandom_range(0, 3), ln + 1, -1,
                  1'($urandom_range(0, 1)), gap);
            last_d = win_d;
            if (win_d) pend_d = 1'b0; else pend_i = 1'b0;
        end
        i_arvalid = 1'b0; d_arvalid = 1'b0;
        @(negedge clk);
        chk("random_no_err", 32'(o_err), 32'd0);

        // Burst ended one beat early: still returns to IDLE, error is sticky.
        i_arvalid = 1'b1; i_araddr = 32'h0000_1000; i_arlen = 8'd7;
        serve(1'b0, 32'h0000_1000, 8'd7, 0, 7, -1, 1'b0, gap);
        @(negedge clk);
        chk("err_short_burst", 32'(o_err), 32'd1);
        d_arvalid = 1'b1; d_araddr = 32'h0000_2000; d_arlen = 8'd1;
        serve(1'b1, 32'h0000_2000, 8'd1, 0, 2, -1, 1'b0, gap);
        @(negedge clk);
        chk("err_sticky", 32'(o_err), 32'd1);

        // Wrong RID on one beat.
        do_reset();
        @(negedge clk);
        chk("err_cleared_by_reset", 32'(o_err), 32'd0);
        i_arvalid = 1'b1; i_araddr = 32'h0000_3000; i_arlen = 8'd3;
        serve(1'b0, 32'h0000_3000, 8'd3, 1, 4, 1, 1'b0, gap);
        @(negedge clk);
        chk("err_rid", 32'(o_err), 32'd1);

        // Reset in the middle of an 8-beat burst.
        do_reset();
        i_arvalid = 1'b1; i_araddr = 32'h0000_4000; i_arlen = 8'd7;
        wait_ar(gap);
        chk("mid_arvalid_seen", 32'(gap <= 50), 32'd1);
        arready = 1'b1;
        tick();
        arready = 1'b0; i_arvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rvalid = 1'b1; rdata = 32'hA0 + 32'(k); rlast = 1'b0; rid = 4'd0;
            tick();
        end
        resetn = 1'b0;
        tick();
        @(negedge clk);
        chk("mid_rst_ctl", 32'({o_arvalid, o_rready, o_err, o_i_arready, o_d_arready,
                                o_i_rvalid, o_d_rvalid, o_i_rlast, o_d_rlast}), 32'd0);
        chk("mid_rst_fields", 32'({o_arid, o_arlen}), 32'd0);
        chk("mid_rst_araddr", o_araddr, 32'd0);
        tick();
        resetn = 1'b1; rvalid = 1'b0;
        i_arvalid = 1'b1; i_araddr = 32'h0000_5000; i_arlen = 8'd2;
        serve(1'b0, 32'h0000_5000, 8'd2, 0, 3, -1, 1'b0, gap);
        @(negedge clk);
        chk("after_rst_no_err", 32'(o_err), 32'd0);

        // Fixed-priority instance: D-cache wins every tie, I-cache only once D is idle.
        sel_fp = 1'b1;
        i_arvalid = 1'b0; d_arvalid = 1'b0;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            i_arvalid = 1'b1; d_arvalid = 1'b1;
            i_araddr = 32'h1FC0_0000 + 32'(r * 64); d_araddr = 32'h9000_0000 + 32'(r * 64);
            i_arlen = 8'd1; d_arlen = 8'(r);
            serve(1'b1, d_araddr, 8'(r), r, r + 1, -1, 1'b0, gap);
        end
        serve(1'b0, i_araddr, 8'd1, 0, 2, -1, 1'b0, gap);
        @(negedge clk);
        chk("fp_no_err", 32'(o_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
